// File: rtl/pcs_link_pkg.sv
// pcs_link_pkg: shared types and constants for the SFP PCS link-bring-up
// controller (state encoding, status-vector bit positions, speed codes).
package pcs_link_pkg;

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LINK = 2'd1,
    ST_DEBOUNCE  = 2'd2,
    ST_UP        = 2'd3
  } state_t;

  // Bit positions inside the PCS status vector
  localparam int SV_LINK     = 0;
  localparam int SV_DISPERR  = 5;
  localparam int SV_NOTINTBL = 6;

  // SGMII speed select codes
  localparam logic [1:0] SPD_1G   = 2'b10;
  localparam logic [1:0] SPD_100M = 2'b01;
  localparam logic [1:0] SPD_10M  = 2'b00;

  // 8-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pcs_link_stats.sv
// pcs_link_stats: saturating link-drop and code-error counters for the PCS
// link controller. Only built when PCS_LINK_CTRL_STATS_EN is defined.
`ifdef PCS_LINK_CTRL_STATS_EN
module pcs_link_stats
  import pcs_link_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_drop_inc,
  input  logic        i_err_inc,
  output logic [7:0]  o_drop_cnt,
  output logic [15:0] o_err_cnt
);

  logic [7:0]  r_drop_cnt;
  logic [15:0] r_err_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counters: clear has priority over any increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (i_clr) begin
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (i_drop_inc) r_drop_cnt <= sat_inc8(r_drop_cnt);
      if (i_err_inc)  r_err_cnt  <= sat_inc16(r_err_cnt);
    end
  end

  assign o_drop_cnt = r_drop_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule
`endif

// File: rtl/pcs_link_ctrl.sv
// pcs_link_ctrl: link-bring-up controller for the 1000BASE-X/SGMII PCS on
// the SFP port. Sequences the PCS reset, latches mode/speed selects during
// reset, debounces PCS link status into LINK_UP and retries on timeout.
// Optional statistics counters are enabled with PCS_LINK_CTRL_STATS_EN.
module pcs_link_ctrl
  import pcs_link_pkg::*;
#(
  parameter int RST_HOLD_CYC = 1000,
  parameter int LINK_TO_CYC  = 2000000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int CNT_W        = 21
) (
  input  logic        CLK_200M,
  input  logic        RESET_N,
  input  logic        CFG_SEL_SGMII,
  input  logic [1:0]  CFG_SPEED,
  input  logic        FORCE_RESTART,
  input  logic [15:0] STATUS_VECTOR,
`ifdef PCS_LINK_CTRL_STATS_EN
  input  logic        STAT_CLR,
  output logic [7:0]  LINK_DROP_CNT,
  output logic [15:0] CODE_ERR_CNT,
`endif
  output logic        PCS_RESET,
  output logic        SEL_SGMII,
  output logic [1:0]  SGMII_LINK,
  output logic        LINK_UP,
  output logic [1:0]  CTRL_STATE,
  output logic [7:0]  RETRY_CNT
);

  // Terminal timer values: a state lasts N cycles when the timer runs 0..N-1
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LINK_LAST = CNT_W'(LINK_TO_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic             r_pcs_reset;
  logic             r_link_up;
  logic             r_sel_sgmii;
  logic [1:0]       r_sgmii_link;
  logic [7:0]       r_retry_cnt;
  logic             w_link;
  logic             w_restart;
  logic             w_timeout;
  logic             w_load_cfg;
  logic             w_unused_sv;

  assign w_link      = STATUS_VECTOR[SV_LINK];
  // Remaining status bits are informational only in the base build
  assign w_unused_sv = ^STATUS_VECTOR[15:1];

  // Next-state logic; a restart request overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_restart   = FORCE_RESTART ||
                  ((r_state != ST_RST) && (CFG_SEL_SGMII != r_sel_sgmii));
    case (r_state)
      ST_RST: begin
        if (r_timer == RST_LAST) w_state_nxt = ST_WAIT_LINK;
      end
      ST_WAIT_LINK: begin
        if (w_link) begin
          w_state_nxt = ST_DEBOUNCE;
        end else if (r_timer == LINK_LAST) begin
          w_state_nxt = ST_RST;
          w_timeout   = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!w_link)                 w_state_nxt = ST_WAIT_LINK;
        else if (r_timer == DEB_LAST) w_state_nxt = ST_UP;
      end
      ST_UP: begin
        if (!w_link) w_state_nxt = ST_WAIT_LINK;
      end
      default: w_state_nxt = ST_RST;
    endcase
    if (w_restart) begin
      w_state_nxt = ST_RST;
      w_timeout   = 1'b0;
    end
  end

  // Mode/speed follow the config on every RST cycle, including the entry
  // edge, so the PCS sees the new selects for the whole reset pulse
  assign w_load_cfg = (r_state == ST_RST) || (w_state_nxt == ST_RST);

  // State register and shared timer, cleared on every state (re)entry
  always_ff @(posedge CLK_200M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_RST;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || w_restart) r_timer <= '0;
      else if (r_timer != '1)                    r_timer <= r_timer + CNT_W'(1);
    end
  end

  // Registered outputs derived from the next state and latched config
  always_ff @(posedge CLK_200M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pcs_reset  <= 1'b1;
      r_link_up    <= 1'b0;
      r_sel_sgmii  <= 1'b0;
      r_sgmii_link <= SPD_1G;
      r_retry_cnt  <= '0;
    end else begin
      r_pcs_reset <= (w_state_nxt == ST_RST);
      r_link_up   <= (w_state_nxt == ST_UP);
      if (w_load_cfg) begin
        r_sel_sgmii  <= CFG_SEL_SGMII;
        r_sgmii_link <= CFG_SPEED;
      end
      if (w_timeout) r_retry_cnt <= sat_inc8(r_retry_cnt);
    end
  end

  assign PCS_RESET  = r_pcs_reset;
  assign LINK_UP    = r_link_up;
  assign SEL_SGMII  = r_sel_sgmii;
  assign SGMII_LINK = r_sgmii_link;
  assign CTRL_STATE = r_state;
  assign RETRY_CNT  = r_retry_cnt;

`ifdef PCS_LINK_CTRL_STATS_EN
  logic w_drop_inc;
  logic w_err_inc;

  assign w_drop_inc = (r_state == ST_UP) && (w_state_nxt == ST_WAIT_LINK);
  assign w_err_inc  = (r_state == ST_UP) &&
                      (STATUS_VECTOR[SV_DISPERR] || STATUS_VECTOR[SV_NOTINTBL]);

  pcs_link_stats u_stats (
    .clk        (CLK_200M),
    .rst_n      (RESET_N),
    .i_clr      (STAT_CLR),
    .i_drop_inc (w_drop_inc),
    .i_err_inc  (w_err_inc),
    .o_drop_cnt (LINK_DROP_CNT),
    .o_err_cnt  (CODE_ERR_CNT)
  );
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// tb_pcs_link_ctrl: directed bench for pcs_link_ctrl with short timers
// (hold 4, link timeout 20, debounce 5). Statistics checks are compiled
// when PCS_LINK_CTRL_STATS_EN is defined.
module tb_pcs_link_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_sel;
  logic [1:0]  cfg_spd;
  logic        force_rs;
  logic [15:0] sv;
  logic        pcs_reset;
  logic        sel_sgmii;
  logic [1:0]  sgmii_link;
  logic        link_up;
  logic [1:0]  ctrl_state;
  logic [7:0]  retry_cnt;
`ifdef PCS_LINK_CTRL_STATS_EN
  logic        stat_clr;
  logic [7:0]  drop_cnt;
  logic [15:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pcs_link_ctrl #(
    .RST_HOLD_CYC (4),
    .LINK_TO_CYC  (20),
    .DEBOUNCE_CYC (5),
    .CNT_W        (21)
  ) dut (
    .CLK_200M      (clk),
    .RESET_N       (rst_n),
    .CFG_SEL_SGMII (cfg_sel),
    .CFG_SPEED     (cfg_spd),
    .FORCE_RESTART (force_rs),
    .STATUS_VECTOR (sv),
`ifdef PCS_LINK_CTRL_STATS_EN
    .STAT_CLR      (stat_clr),
    .LINK_DROP_CNT (drop_cnt),
    .CODE_ERR_CNT  (err_cnt),
`endif
    .PCS_RESET     (pcs_reset),
    .SEL_SGMII     (sel_sgmii),
    .SGMII_LINK    (sgmii_link),
    .LINK_UP       (link_up),
    .CTRL_STATE    (ctrl_state),
    .RETRY_CNT     (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [1:0] spd;
    logic       frc;
    logic       link;
    logic       exp_prst;
    logic       exp_lup;
    logic [1:0] exp_state;
    logic       exp_sel;
    logic [1:0] exp_spd;
    logic [7:0] exp_retry;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cfg_sel  = 1'b0;
    cfg_spd  = 2'b10;
    force_rs = 1'b0;
    sv       = 16'h0000;
`ifdef PCS_LINK_CTRL_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic add(input logic s, input logic [1:0] sp, input logic f, input logic l,
                     input logic p, input logic u, input logic [1:0] st,
                     input logic es, input logic [1:0] esp, input logic [7:0] r);
    vec_t v;
    v = '{s, sp, f, l, p, u, st, es, esp, r};
    tbl.push_back(v);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, ctrl_state, 2'd0);
    chk({tag, "_prst"},  pcs_reset,  1'b1);
    chk({tag, "_lup"},   link_up,    1'b0);
    chk({tag, "_retry"}, retry_cnt,  8'd0);
    chk({tag, "_sel"},   sel_sgmii,  1'b0);
    chk({tag, "_spd"},   sgmii_link, 2'b10);
  endtask

  initial begin
    logic exp_p;
    logic [7:0] exp_r;

    // ---- Power-up with no link: 4 high / 20 low / repeat, retries count
    do_reset();
    chk_reset_vals("por");
    for (int k = 1; k <= 48; k++) begin
      step();
      exp_p = (k <= 3) || (k >= 24 && k <= 27) || (k == 48);
      exp_r = (k < 24) ? 8'd0 : ((k < 48) ? 8'd1 : 8'd2);
      chk($sformatf("nolink_c%0d_prst", k), pcs_reset, exp_p);
      chk($sformatf("nolink_c%0d_state", k), ctrl_state, exp_p ? 2'd0 : 2'd1);
      chk($sformatf("nolink_c%0d_retry", k), retry_cnt, exp_r);
    end

    // ---- New config latched during RST, then async reset mid-DEBOUNCE
    cfg_sel = 1'b1;
    cfg_spd = 2'b01;
    repeat (4) step();
    chk("relatch_state", ctrl_state, 2'd1);
    chk("relatch_sel",   sel_sgmii,  1'b1);
    chk("relatch_spd",   sgmii_link, 2'b01);
    sv = 16'h0001;
    step();
    step();
    chk("middeb_state", ctrl_state, 2'd2);
    chk("middeb_retry", retry_cnt,  8'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");

    // ---- Table: link rise, glitch, force restart, speed/mode change
    //   sel spd    frc link | prst lup st  sel spd    retry
    add(0, 2'b10, 0, 0,   1, 0, 2'd0, 0, 2'b10, 0);   // 1
    add(0, 2'b10, 0, 0,   1, 0, 2'd0, 0, 2'b10, 0);
    add(0, 2'b10, 0, 0,   1, 0, 2'd0, 0, 2'b10, 0);
    add(0, 2'b10, 0, 0,   0, 0, 2'd1, 0, 2'b10, 0);   // 4 enter WAIT_LINK
    add(0, 2'b10, 0, 0,   0, 0, 2'd1, 0, 2'b10, 0);
    add(0, 2'b10, 0, 0,   0, 0, 2'd1, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);   // 7 link rises
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);   // 11 still debouncing
    add(0, 2'b10, 0, 1,   0, 1, 2'd3, 0, 2'b10, 0);   // 12 UP, 6th edge
    add(0, 2'b10, 0, 1,   0, 1, 2'd3, 0, 2'b10, 0);
    add(0, 2'b10, 0, 0,   0, 0, 2'd1, 0, 2'b10, 0);   // 14 link drop
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 0,   0, 0, 2'd1, 0, 2'b10, 0);   // 17 glitch low
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);   // 18 debounce restarts
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);
    add(0, 2'b10, 0, 1,   0, 0, 2'd2, 0, 2'b10, 0);   // 22
    add(0, 2'b10, 0, 1,   0, 1, 2'd3, 0, 2'b10, 0);   // 23 UP
    add(0, 2'b01, 1, 0,   1, 0, 2'd0, 0, 2'b01, 0);   // 24 force + drop
    add(0, 2'b01, 0, 0,   1, 0, 2'd0, 0, 2'b01, 0);
    add(0, 2'b01, 0, 0,   1, 0, 2'd0, 0, 2'b01, 0);
    add(0, 2'b01, 0, 0,   1, 0, 2'd0, 0, 2'b01, 0);
    add(0, 2'b01, 0, 0,   0, 0, 2'd1, 0, 2'b01, 0);   // 28 WAIT_LINK
    add(0, 2'b01, 0, 1,   0, 0, 2'd2, 0, 2'b01, 0);
    add(0, 2'b01, 0, 1,   0, 0, 2'd2, 0, 2'b01, 0);
    add(0, 2'b01, 0, 1,   0, 0, 2'd2, 0, 2'b01, 0);
    add(0, 2'b01, 0, 1,   0, 0, 2'd2, 0, 2'b01, 0);
    add(0, 2'b01, 0, 1,   0, 0, 2'd2, 0, 2'b01, 0);
    add(0, 2'b01, 0, 1,   0, 1, 2'd3, 0, 2'b01, 0);   // 34 UP
    add(0, 2'b00, 0, 1,   0, 1, 2'd3, 0, 2'b01, 0);   // 35 speed change ignored
    add(1, 2'b00, 0, 1,   1, 0, 2'd0, 1, 2'b00, 0);   // 36 mode change restart
    add(1, 2'b00, 0, 1,   1, 0, 2'd0, 1, 2'b00, 0);

    do_reset();
    foreach (tbl[i]) begin
      cfg_sel  = tbl[i].sel;
      cfg_spd  = tbl[i].spd;
      force_rs = tbl[i].frc;
      sv       = {15'd0, tbl[i].link};
      step();
      chk($sformatf("row%0d_prst",  i + 1), pcs_reset,  tbl[i].exp_prst);
      chk($sformatf("row%0d_lup",   i + 1), link_up,    tbl[i].exp_lup);
      chk($sformatf("row%0d_state", i + 1), ctrl_state, tbl[i].exp_state);
      chk($sformatf("row%0d_sel",   i + 1), sel_sgmii,  tbl[i].exp_sel);
      chk($sformatf("row%0d_spd",   i + 1), sgmii_link, tbl[i].exp_spd);
      chk($sformatf("row%0d_retry", i + 1), retry_cnt,  tbl[i].exp_retry);
    end
    force_rs = 1'b0;

    // ---- Retry counter saturation (one timeout every 24 cycles)
    do_reset();
    for (int k = 1; k <= 24 * 258; k++) begin
      step();
      if (k == 24 * 254 + 5) chk("sat_254", retry_cnt, 8'd254);
      if (k == 24 * 255 + 5) chk("sat_255", retry_cnt, 8'd255);
      if (k == 24 * 257 + 5) chk("sat_hold", retry_cnt, 8'd255);
    end

`ifdef PCS_LINK_CTRL_STATS_EN
    // ---- Statistics counters
    do_reset();
    chk("st_reset_err",  err_cnt,  16'd0);
    chk("st_reset_drop", drop_cnt, 8'd0);
    sv = 16'h0001;
    repeat (10) step();
    chk("st_up_state", ctrl_state, 2'd3);
    sv = 16'h0041;
    repeat (3) step();
    chk("st_err3", err_cnt, 16'd3);
    sv = 16'h0021;
    step();
    chk("st_err4_disperr", err_cnt, 16'd4);
    sv = 16'h0000;
    step();
    chk("st_drop1", drop_cnt, 8'd1);
    chk("st_drop_state", ctrl_state, 2'd1);
    sv = 16'h0001;
    repeat (6) step();
    chk("st_up2_state", ctrl_state, 2'd3);
    sv = 16'h0041;
    stat_clr = 1'b1;
    step();
    chk("st_clr_err",  err_cnt,  16'd0);
    chk("st_clr_drop", drop_cnt, 8'd0);
    stat_clr = 1'b0;
    step();
    chk("st_after_clr_err", err_cnt, 16'd1);
    sv = 16'h0001;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pcs_link_ctrl.md
# pcs_link_ctrl

Link-bring-up controller for the 1000BASE-X/SGMII PCS/PMA wrapper on the SFP port. It owns the PCS reset, drives the SGMII mode and speed selects, and watches the PCS status vector. It debounces link status into a clean `LINK_UP` for SiTCP. On link-acquisition timeout, mode change or software request, it re-runs the PCS reset sequence.

## Interface
Parameters:
- `RST_HOLD_CYC`, default 1000: cycles `PCS_RESET` is held high per reset pulse (5 µs at 200 MHz).
- `LINK_TO_CYC`, default 2000000: cycles allowed in WAIT_LINK before retry (10 ms).
- `DEBOUNCE_CYC`, default 20000: cycles link must stay high before `LINK_UP` (100 µs).
- `CNT_W`, default 21: timer width; must hold the largest of the three values above.

Ports:
- `CLK_200M`, in, 1: sole clock.
- `RESET_N`, in, 1: asynchronous, active-low reset.
- `CFG_SEL_SGMII`, in, 1: requested mode; 1 = SGMII, 0 = 1000BASE-X.
- `CFG_SPEED`, in, 2: requested SGMII speed; 10 = 1G, 01 = 100M, 00 = 10M.
- `FORCE_RESTART`, in, 1: single-cycle pulse that restarts bring-up.
- `STATUS_VECTOR`, in, 16: PCS status. Bit0 is link status; bit5 is rx disparity error; bit6 is rx not-in-table.
- `PCS_RESET`, out, 1: active-high reset to the PCS wrapper.
- `SEL_SGMII`, out, 1: latched mode select to the PCS.
- `SGMII_LINK`, out, 2: latched speed select to the PCS.
- `LINK_UP`, out, 1: debounced link.
- `CTRL_STATE`, out, 2: current state encoding.
- `RETRY_CNT`, out, 8: timeout retries since reset; saturates at 255.

## Operation
- States: RST=0, WAIT_LINK=1, DEBOUNCE=2, UP=3. One timer of width `CNT_W` is shared by all states and cleared on every state entry.
- RST:
  - `PCS_RESET`=1 and `LINK_UP`=0.
  - `SEL_SGMII` and `SGMII_LINK` load `CFG_SEL_SGMII` and `CFG_SPEED` every cycle.
  - When the timer reaches `RST_HOLD_CYC`-1, go to WAIT_LINK.
- WAIT_LINK:
  - `PCS_RESET`=0.
  - If `STATUS_VECTOR[0]`=1, go to DEBOUNCE.
  - Otherwise, when the timer reaches `LINK_TO_CYC`-1, go to RST and increment `RETRY_CNT` (saturating).
- DEBOUNCE:
  - If `STATUS_VECTOR[0]`=0, go to WAIT_LINK with a fresh timeout.
  - When the timer reaches `DEBOUNCE_CYC`-1 with link still high, go to UP.
- UP:
  - `LINK_UP`=1.
  - If `STATUS_VECTOR[0]`=0, go to WAIT_LINK; `LINK_UP` drops in the same transition.
- Restart conditions, evaluated in any state including RST:
  - Triggers: `FORCE_RESTART`=1, or `CFG_SEL_SGMII` differing from the latched `SEL_SGMII` outside RST.
  - Action: go to RST with the timer cleared. `RETRY_CNT` is not incremented.
  - Priority: a restart beats every other transition in the same cycle.
- `CFG_SPEED` changes outside RST are ignored until the next RST. Speed changes need an explicit `FORCE_RESTART`.
- `STATUS_VECTOR` comes from the PCS user clock domain, which is `CLK_200M`-synchronous via the wrapper. No synchronizer is needed.

## Timing
- Reset values:
  - State RST, timer 0, `PCS_RESET`=1, `LINK_UP`=0, `RETRY_CNT`=0.
  - `SEL_SGMII`=0, `SGMII_LINK`=2'b10, `CTRL_STATE`=0.
- All outputs are registered, with a 1-cycle latency from the input condition to the output change.
- From `RESET_N` deassertion, `PCS_RESET` is high for exactly `RST_HOLD_CYC` cycles.
- Link high continuously from WAIT_LINK entry gives `LINK_UP` after 1 + `DEBOUNCE_CYC` cycles.
- `RESET_N` asserted mid-operation forces all reset values immediately, asynchronously.

## Configuration
- `PCS_LINK_CTRL_STATS_EN` defined: adds the following.
  - Input `STAT_CLR` (1) and outputs `LINK_DROP_CNT` (8) and `CODE_ERR_CNT` (16).
  - `LINK_DROP_CNT` increments on each UP→WAIT_LINK transition.
  - `CODE_ERR_CNT` increments each UP cycle where `STATUS_VECTOR[5]` or `STATUS_VECTOR[6]` is high.
  - Both counters saturate and are cleared by `STAT_CLR`; clear wins over increment.
- `PCS_LINK_CTRL_STATS_EN` undefined: those ports and counters do not exist.

## Structure
- Shared package `pcs_link_pkg` holds:
  - The state enum.
  - Status-bit index constants (`SV_LINK`=0, `SV_DISPERR`=5, `SV_NOTINTBL`=6).
  - Speed constants (`SPD_1G`=2'b10, `SPD_100M`=2'b01, `SPD_10M`=2'b00).
- One natural sub-module, `pcs_link_stats`: the saturating counter pair, instantiated only under the macro.

## Test plan
Bench parameters: `RST_HOLD_CYC`=4, `LINK_TO_CYC`=20, `DEBOUNCE_CYC`=5.
- Power-up, link never comes: `PCS_RESET` high 4 cycles, low 20 cycles, then high again. `RETRY_CNT`=1, then 2 after the next period.
- Link rises at cycle 3 of WAIT_LINK and stays high: `LINK_UP`=1 exactly 6 cycles after the rise; `CTRL_STATE`=3.
- Link glitches low for 1 cycle during DEBOUNCE: back to WAIT_LINK, `LINK_UP` stays 0, debounce restarts on the next rise.
- In UP, `FORCE_RESTART` pulse coincident with link drop: next state RST, `LINK_UP`=0, `RETRY_CNT` unchanged. With `CFG_SPEED`=01, `SGMII_LINK`=01 from the first RST cycle.
- In UP, `CFG_SEL_SGMII` toggles 0→1: RST entered next cycle and `SEL_SGMII`=1. `RESET_N` pulsed low mid-DEBOUNCE gives all reset values immediately.
- With `PCS_LINK_CTRL_STATS_EN` defined, in UP:
  - 3 cycles of `STATUS_VECTOR[6]`=1 give `CODE_ERR_CNT`=3.
  - A link drop gives `LINK_DROP_CNT`=1.
  - `STAT_CLR` coincident with an error cycle leaves `CODE_ERR_CNT`=0.
